// File: rtl/ptw_axi_read_master.sv
// Single-outstanding AXI4 read master that fetches one 64-bit PTE per walker request
// and returns it as a data-valid pulse, or as an access-fault pulse on an error response.
module ptw_axi_read_master #(
  parameter int          ADDR_WIDTH = 64,
  parameter int          DATA_WIDTH = 64,
  parameter int          ID_WIDTH   = 4,
  parameter int unsigned AXI_ID     = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ADDR_VALID,
  input  logic [ADDR_WIDTH-1:0] ADDR,
  output logic                  DATA_VALID,
  output logic [DATA_WIDTH-1:0] DATA,
  output logic                  ACCESS_FAULT,
  output logic                  BUSY,
  output logic                  REQ_OVERRUN,
  output logic [1:0]            DBG_STATE,
  output logic [ID_WIDTH-1:0]   M_AXI_ARID,
  output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]            M_AXI_ARLEN,
  output logic [2:0]            M_AXI_ARSIZE,
  output logic [1:0]            M_AXI_ARBURST,
  output logic [3:0]            M_AXI_ARCACHE,
  output logic [2:0]            M_AXI_ARPROT,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  input  logic [ID_WIDTH-1:0]   M_AXI_RID,
  input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RLAST,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY
);

  // Handshakes: a channel transfers on a rising edge where VALID and READY are both high;
  // ARVALID, once raised, stays high with ARADDR stable until that transfer.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_AR   = 2'd1;
  localparam logic [1:0] S_R    = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic                  r_arvalid;
  logic                  r_rready;
  logic                  r_first;
  logic [DATA_WIDTH-1:0] r_cap_data;
  logic                  r_cap_err;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_data_valid;
  logic                  r_access_fault;
  logic                  r_busy;
  logic                  r_req_overrun;

  logic                  w_r_beat;
  logic [DATA_WIDTH-1:0] w_beat_data;
  logic                  w_beat_err;
  logic                  w_unused;

  assign w_r_beat = M_AXI_RVALID & r_rready;
  // Only the first beat counts; later beats from an ARLEN-ignoring slave are dropped.
  assign w_beat_data = r_first ? M_AXI_RDATA    : r_cap_data;
  assign w_beat_err  = r_first ? M_AXI_RRESP[1] : r_cap_err;
  assign w_unused    = ^{M_AXI_RID, M_AXI_RRESP[0], ADDR[2:0]};

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state        <= S_IDLE;
      r_araddr       <= '0;
      r_arvalid      <= 1'b0;
      r_rready       <= 1'b0;
      r_first        <= 1'b0;
      r_cap_data     <= '0;
      r_cap_err      <= 1'b0;
      r_data         <= '0;
      r_data_valid   <= 1'b0;
      r_access_fault <= 1'b0;
      r_busy         <= 1'b0;
      r_req_overrun  <= 1'b0;
    end else begin
      r_data_valid   <= 1'b0;
      r_access_fault <= 1'b0;
      case (r_state)
        S_IDLE, S_RESP: begin
          if (ADDR_VALID) begin
            r_araddr  <= {ADDR[ADDR_WIDTH-1:3], 3'b000};
            r_arvalid <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= S_AR;
          end else begin
            r_state   <= S_IDLE;
          end
        end
        S_AR: begin
          if (ADDR_VALID) r_req_overrun <= 1'b1;
          if (M_AXI_ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_first   <= 1'b1;
            r_state   <= S_R;
          end
        end
        S_R: begin
          if (ADDR_VALID) r_req_overrun <= 1'b1;
          if (w_r_beat) begin
            r_first    <= 1'b0;
            r_cap_data <= w_beat_data;
            r_cap_err  <= w_beat_err;
            if (M_AXI_RLAST) begin
              r_rready <= 1'b0;
              r_busy   <= 1'b0;
              r_state  <= S_RESP;
              if (w_beat_err) begin
                r_access_fault <= 1'b1;
              end else begin
                r_data_valid <= 1'b1;
                r_data       <= w_beat_data;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign DATA_VALID    = r_data_valid;
  assign DATA          = r_data;
  assign ACCESS_FAULT  = r_access_fault;
  assign BUSY          = r_busy;
  assign REQ_OVERRUN   = r_req_overrun;
  assign DBG_STATE     = r_state;
  assign M_AXI_ARID    = ID_WIDTH'(AXI_ID);
  assign M_AXI_ARADDR  = r_araddr;
  assign M_AXI_ARLEN   = 8'd0;
  assign M_AXI_ARSIZE  = 3'b011;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARCACHE = 4'b0011;
  assign M_AXI_ARPROT  = 3'b001;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_ptw_axi_read_master.sv
// Bench for ptw_axi_read_master: table of PTE fetches against a scripted AXI slave,
// with a scoreboard for responses and AR addresses, plus overrun and reset sequences.
module tb_ptw_axi_read_master;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ADDR_VALID;
  logic [63:0] ADDR;
  logic        DATA_VALID;
  logic [63:0] DATA;
  logic        ACCESS_FAULT;
  logic        BUSY;
  logic        REQ_OVERRUN;
  logic [1:0]  DBG_STATE;
  logic [3:0]  M_AXI_ARID;
  logic [63:0] M_AXI_ARADDR;
  logic [7:0]  M_AXI_ARLEN;
  logic [2:0]  M_AXI_ARSIZE;
  logic [1:0]  M_AXI_ARBURST;
  logic [3:0]  M_AXI_ARCACHE;
  logic [2:0]  M_AXI_ARPROT;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY;
  logic [3:0]  M_AXI_RID;
  logic [63:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RLAST;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;

  ptw_axi_read_master dut (
    .CLK(CLK), .RST(RST), .ADDR_VALID(ADDR_VALID), .ADDR(ADDR),
    .DATA_VALID(DATA_VALID), .DATA(DATA), .ACCESS_FAULT(ACCESS_FAULT),
    .BUSY(BUSY), .REQ_OVERRUN(REQ_OVERRUN), .DBG_STATE(DBG_STATE),
    .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
    .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST),
    .M_AXI_ARCACHE(M_AXI_ARCACHE), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RID(M_AXI_RID), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  logic [64:0] exp_q[$];
  logic [63:0] exp_ar_q[$];
  logic [63:0] data_hold;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    int          ar_wait;
    int          r_wait;
    int          nbeats;
    bit          ovr;
    logic [63:0] exp_araddr;
    bit          exp_fault;
    logic [63:0] exp_data;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // scoreboard: responses and AR addresses are popped as the DUT produces them
  always @(negedge CLK) begin
    logic [64:0] e;
    if (RST) begin
      data_hold = 64'd0;
    end else begin
      check_bit("pulse_exclusive", DATA_VALID & ACCESS_FAULT, 1'b0);
      if (DATA_VALID || ACCESS_FAULT) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_resp: got dv=%b af=%b expected no response", DATA_VALID, ACCESS_FAULT);
        end else begin
          e = exp_q.pop_front();
          check_bit("resp_fault", ACCESS_FAULT, e[64]);
          check("resp_data", DATA, e[63:0]);
        end
        data_hold = DATA;
      end else begin
        check("data_stable", DATA, data_hold);
      end
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        if (exp_ar_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_ar: got araddr=%h expected no AR", M_AXI_ARADDR);
        end else begin
          check("ar_addr", M_AXI_ARADDR, exp_ar_q.pop_front());
        end
      end
    end
  end

  // driver: one walker request plus the slave side of its AXI read
  task automatic do_read(input vec_t v);
    @(posedge CLK); #1;
    ADDR_VALID = 1'b1;
    ADDR       = v.addr;
    exp_q.push_back({v.exp_fault, v.exp_data});
    exp_ar_q.push_back(v.exp_araddr);
    @(posedge CLK); #1;
    ADDR_VALID    = 1'b0;
    ADDR          = {$urandom, $urandom};
    M_AXI_ARREADY = 1'b0;
    for (int i = 0; i < v.ar_wait; i++) begin
      @(negedge CLK);
      check_bit("ar_hold_valid", M_AXI_ARVALID, 1'b1);
      check("ar_hold_addr", M_AXI_ARADDR, v.exp_araddr);
      check_bit("busy_ar", BUSY, 1'b1);
      @(posedge CLK); #1;
    end
    M_AXI_ARREADY = 1'b1;
    @(negedge CLK);
    check_bit("arvalid", M_AXI_ARVALID, 1'b1);
    check("araddr", M_AXI_ARADDR, v.exp_araddr);
    check_bit("busy_ar", BUSY, 1'b1);
    @(posedge CLK); #1;
    M_AXI_ARREADY = 1'b0;
    if (v.ovr) begin
      ADDR_VALID = 1'b1;
      ADDR       = 64'h0000_0000_9000_0040;
      @(negedge CLK);
      check_bit("rready_ovr", M_AXI_RREADY, 1'b1);
      @(posedge CLK); #1;
      ADDR_VALID = 1'b0;
    end
    for (int i = 0; i < v.r_wait; i++) begin
      @(negedge CLK);
      check_bit("rready_wait", M_AXI_RREADY, 1'b1);
      check_bit("busy_r", BUSY, 1'b1);
      check_bit("arvalid_low", M_AXI_ARVALID, 1'b0);
      @(posedge CLK); #1;
    end
    for (int b = 0; b < v.nbeats; b++) begin
      M_AXI_RVALID = 1'b1;
      M_AXI_RDATA  = (b == 0) ? v.rdata : ~v.rdata;
      M_AXI_RRESP  = (b == 0) ? v.rresp : ~v.rresp;
      M_AXI_RLAST  = (b == v.nbeats - 1);
      M_AXI_RID    = 4'($urandom_range(0, 15));
      @(negedge CLK);
      check_bit("rready_beat", M_AXI_RREADY, 1'b1);
      check_bit("no_early_resp", DATA_VALID | ACCESS_FAULT, 1'b0);
      @(posedge CLK); #1;
    end
    M_AXI_RVALID = 1'b0;
    M_AXI_RLAST  = 1'b0;
    M_AXI_RRESP  = 2'b00;
    M_AXI_RDATA  = {$urandom, $urandom};
    @(negedge CLK);
    check_bit("resp_dv", DATA_VALID, !v.exp_fault);
    check_bit("resp_af", ACCESS_FAULT, v.exp_fault);
    check_bit("busy_resp", BUSY, 1'b0);
    check_bit("rready_resp", M_AXI_RREADY, 1'b0);
  endtask

  initial begin
    vecs[0] = '{64'h0000_0000_8000_1007, 64'h0000_0000_2000_04CF, 2'b00, 0, 0, 1, 1'b0,
                64'h0000_0000_8000_1000, 1'b0, 64'h0000_0000_2000_04CF};
    vecs[1] = '{64'h0000_0000_8000_5018, 64'hBAD0_BAD0_BAD0_BAD0, 2'b10, 0, 0, 1, 1'b0,
                64'h0000_0000_8000_5018, 1'b1, 64'h0000_0000_2000_04CF};
    vecs[2] = '{64'h0000_0040_8000_4005, 64'h1111_2222_3333_4441, 2'b01, 5, 7, 1, 1'b0,
                64'h0000_0040_8000_4000, 1'b0, 64'h1111_2222_3333_4441};
    vecs[3] = '{64'h0000_0000_8000_6ABF, 64'h0000_0000_0000_5555, 2'b11, 1, 2, 1, 1'b0,
                64'h0000_0000_8000_6AB8, 1'b1, 64'h1111_2222_3333_4441};
    vecs[4] = '{64'h0000_0000_8000_0000, 64'h0000_0000_2000_0801, 2'b00, 0, 0, 1, 1'b0,
                64'h0000_0000_8000_0000, 1'b0, 64'h0000_0000_2000_0801};
    vecs[5] = '{64'h0000_0000_8000_2008, 64'h0000_0000_2000_0C01, 2'b00, 0, 0, 1, 1'b0,
                64'h0000_0000_8000_2008, 1'b0, 64'h0000_0000_2000_0C01};
    vecs[6] = '{64'h0000_0000_8000_3010, 64'h0000_0000_2040_00CF, 2'b00, 0, 0, 1, 1'b0,
                64'h0000_0000_8000_3010, 1'b0, 64'h0000_0000_2040_00CF};
    vecs[7] = '{64'h0000_0000_8000_8020, 64'h3030_0000_0000_00CF, 2'b00, 0, 2, 2, 1'b1,
                64'h0000_0000_8000_8020, 1'b0, 64'h3030_0000_0000_00CF};
    vecs[8] = '{64'h0000_0000_8000_9000, 64'h0000_0000_0000_7777, 2'b00, 0, 0, 1, 1'b0,
                64'h0000_0000_8000_9000, 1'b0, 64'h0000_0000_0000_7777};

    RST           = 1'b1;
    ADDR_VALID    = 1'b0;
    ADDR          = 64'd0;
    M_AXI_ARREADY = 1'b0;
    M_AXI_RID     = 4'd0;
    M_AXI_RDATA   = 64'd0;
    M_AXI_RRESP   = 2'b00;
    M_AXI_RLAST   = 1'b0;
    M_AXI_RVALID  = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;

    @(negedge CLK);
    check_bit("rst_arvalid", M_AXI_ARVALID, 1'b0);
    check_bit("rst_rready", M_AXI_RREADY, 1'b0);
    check_bit("rst_busy", BUSY, 1'b0);
    check_bit("rst_overrun", REQ_OVERRUN, 1'b0);
    check_bit("rst_dv", DATA_VALID, 1'b0);
    check_bit("rst_af", ACCESS_FAULT, 1'b0);
    check("rst_data", DATA, 64'd0);
    check("rst_araddr", M_AXI_ARADDR, 64'd0);
    check("rst_state", 64'(DBG_STATE), 64'd0);
    check("arid", 64'(M_AXI_ARID), 64'd0);
    check("arlen", 64'(M_AXI_ARLEN), 64'd0);
    check("arsize", 64'(M_AXI_ARSIZE), 64'd3);
    check("arburst", 64'(M_AXI_ARBURST), 64'd1);
    check("arcache", 64'(M_AXI_ARCACHE), 64'd3);
    check("arprot", 64'(M_AXI_ARPROT), 64'd1);

    // single read, error response, backpressure, delayed DECERR
    for (int i = 0; i < 4; i++) do_read(vecs[i]);

    // three-level walk, each request the cycle after the previous response
    for (int i = 4; i < 7; i++) do_read(vecs[i]);
    @(negedge CLK);
    check_bit("walk_no_overrun", REQ_OVERRUN, 1'b0);

    // overrun during R plus a two-beat reply; ARREADY held high to expose any extra AR
    do_read(vecs[7]);
    @(posedge CLK); #1;
    M_AXI_ARREADY = 1'b1;
    repeat (2) begin
      @(negedge CLK);
      check_bit("ovr_no_second_ar", M_AXI_ARVALID, 1'b0);
      check_bit("ovr_sticky", REQ_OVERRUN, 1'b1);
      check_bit("ovr_idle_busy", BUSY, 1'b0);
      @(posedge CLK); #1;
    end
    M_AXI_ARREADY = 1'b0;

    // reset while the AR is stalled
    ADDR_VALID = 1'b1;
    ADDR       = 64'h0000_0000_8000_7000;
    @(posedge CLK); #1;
    ADDR_VALID = 1'b0;
    @(negedge CLK);
    check_bit("pre_rst_arvalid", M_AXI_ARVALID, 1'b1);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check_bit("mid_rst_arvalid", M_AXI_ARVALID, 1'b0);
    check_bit("mid_rst_busy", BUSY, 1'b0);
    check_bit("mid_rst_overrun", REQ_OVERRUN, 1'b0);
    check_bit("mid_rst_dv", DATA_VALID, 1'b0);
    check_bit("mid_rst_af", ACCESS_FAULT, 1'b0);
    check("mid_rst_state", 64'(DBG_STATE), 64'd0);
    repeat (3) @(negedge CLK);
    do_read(vecs[8]);

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("resp_queue_empty", 64'(exp_q.size()), 64'd0);
    check("ar_queue_empty", 64'(exp_ar_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ptw_axi_read_master.md
Name: ptw_axi_read_master

Overview:
- Downstream neighbour of the instruction TLB's page-table walker.
- Accepts one-cycle PTE fetch requests (address-valid pulse plus address) and issues one single-beat 64-bit AXI4 read.
- Returns the PTE to the walker as a one-cycle data-valid pulse, or as an access-fault pulse on an AXI error response.
- One outstanding transaction at a time.

Parameters:
ADDR_WIDTH, 64, width of request address and M_AXI_ARADDR
DATA_WIDTH, 64, PTE/AXI data width; only 64 is supported
ID_WIDTH, 4, AXI ID width
AXI_ID, 0, constant ARID driven on every read

Ports:
CLK  input  1  clock; all logic on rising edge
RST  input  1  reset, synchronous, active-high
ADDR_VALID  input  1  one-cycle request pulse from walker
ADDR  input  ADDR_WIDTH  PTE physical address; bits [2:0] ignored
DATA_VALID  output  1  one-cycle pulse, PTE on DATA
DATA  output  DATA_WIDTH  returned PTE, held until next response
ACCESS_FAULT  output  1  one-cycle pulse, RRESP error on the read
BUSY  output  1  high from request acceptance until the response pulse cycle
REQ_OVERRUN  output  1  sticky; request pulse arrived while busy
M_AXI_ARID  output  ID_WIDTH  = AXI_ID
M_AXI_ARADDR  output  ADDR_WIDTH  latched ADDR with [2:0]=0
M_AXI_ARLEN  output  8  constant 0
M_AXI_ARSIZE  output  3  constant 3'b011
M_AXI_ARBURST  output  2  constant 2'b01
M_AXI_ARCACHE  output  4  constant 4'b0011
M_AXI_ARPROT  output  3  constant 3'b001 (privileged data)
M_AXI_ARVALID  output  1  address valid
M_AXI_ARREADY  input  1  address ready
M_AXI_RID  input  ID_WIDTH  ignored
M_AXI_RDATA  input  DATA_WIDTH  read data
M_AXI_RRESP  input  2  read response
M_AXI_RLAST  input  1  last beat
M_AXI_RVALID  input  1  read valid
M_AXI_RREADY  output  1  read ready

Behaviour:
- Reset (RST high at an edge) forces the following; an in-flight transaction is abandoned with no response pulse:
  - state IDLE
  - ARVALID, RREADY, DATA_VALID, ACCESS_FAULT, BUSY, REQ_OVERRUN = 0
  - DATA = 0, ARADDR = 0
- States: IDLE, AR, R, RESP.
- IDLE:
  - ADDR_VALID=1 at edge t → latch {ADDR[ADDR_WIDTH-1:3],3'b0} into ARADDR, go to AR.
  - ARVALID=1 and BUSY=1 from t+1.
- AR:
  - ARVALID held high, ARADDR stable, until ARVALID&ARREADY at an edge; then ARVALID=0, go to R.
  - ARVALID is never withdrawn before the handshake.
- R:
  - RREADY=1 while in R.
  - On the first RVALID&RREADY beat: capture RDATA and RRESP internally.
  - Beats after the first (non-compliant ARLEN=0 slave) are accepted and discarded.
  - On the beat with RLAST=1 → go to RESP, RREADY=0.
  - A first beat with RVALID&RLAST behaves identically to a single beat.
- RESP, one cycle:
  - Captured RRESP[1]=0 (OKAY/EXOKAY) → DATA_VALID=1, DATA=captured RDATA.
  - Captured RRESP[1]=1 (SLVERR/DECERR) → ACCESS_FAULT=1, DATA unchanged.
  - BUSY=0 in the RESP cycle; next state IDLE.
- Latency with ARREADY and RVALID both immediate:
  - request edge t
  - ARVALID cycle t+1, handshake at t+1
  - RVALID accepted at t+2
  - DATA_VALID cycle t+3
- A request in the RESP cycle or later is accepted normally. The walker pulses its next request the cycle after DATA_VALID, so back-to-back walks see no bubble beyond IDLE.
- ADDR_VALID while BUSY=1 (states AR, R): the request is dropped and REQ_OVERRUN is set (sticky until RST). The current transaction is unaffected.
- DATA_VALID and ACCESS_FAULT are never high together.
- DATA is stable between responses.
- AXI outputs change only on CLK edges; no combinational path from any AXI input to any AXI output.

Test Plan:
1. Single read, zero-wait slave: ADDR_VALID pulse with ADDR=0x0000_0000_8000_1007 → ARADDR=0x8000_1000 at t+1; RDATA=0x0000_0000_2000_04CF, RRESP=0 → DATA_VALID pulse at t+3 with DATA=0x2000_04CF; BUSY high t+1..t+2.
2. Backpressure: ARREADY low 5 cycles, RVALID delayed 7 cycles after AR handshake → ARVALID/ARADDR stable through the stall; exactly one DATA_VALID, 1 cycle after the R beat.
3. Error response: RRESP=2'b10 → ACCESS_FAULT pulse for 1 cycle; DATA_VALID stays 0; DATA retains the previous value (0x2000_04CF).
4. Three-level walk: three requests, each issued the cycle after the prior DATA_VALID (addresses 0x8000_0000, 0x8000_2008, 0x8000_3010) → three ARs in order, three DATA_VALID pulses, REQ_OVERRUN=0.
5. Overrun plus multi-beat: extra ADDR_VALID during R → REQ_OVERRUN=1 and no second AR. Slave returns 2 beats (first RLAST=0) → DATA = first beat, single DATA_VALID after the RLAST beat.
6. Reset mid-operation: RST high while in AR with ARREADY=0 → next cycle ARVALID=0, BUSY=0, REQ_OVERRUN=0; no DATA_VALID or ACCESS_FAULT; a new request afterwards completes normally.
